// File: rtl/intersection_phase_scheduler.sv
// Two-way intersection phase sequencer: timed green/yellow/all-red rotation with
// pedestrian walk service and emergency-vehicle preemption.
module intersection_phase_scheduler #(
   parameter int TICK_DIV = 125_000_000,
   parameter int GREEN_T  = 9,
   parameter int YELLOW_T = 3,
   parameter int ALLRED_T = 1,
   parameter int WALK_T   = 5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ped_btn_ns,
   input  logic       ped_btn_ew,
   input  logic       emg_req,
   input  logic       emg_dir,
   output logic [2:0] light_ns,
   output logic [2:0] light_ew,
   output logic       walk_ns,
   output logic       walk_ew,
   output logic [3:0] countdown,
   output logic [2:0] phase
);

   localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
   localparam logic [3:0] GREEN_CD  = 4'(GREEN_T);
   localparam logic [3:0] YELLOW_CD = 4'(YELLOW_T);
   localparam logic [3:0] ALLRED_CD = 4'(ALLRED_T);
   localparam logic [3:0] WALK_MIN  = 4'(GREEN_T - WALK_T);

   typedef enum logic [2:0] {
      NS_GREEN  = 3'd0,
      NS_YELLOW = 3'd1,
      ALL_RED_A = 3'd2,
      EW_GREEN  = 3'd3,
      EW_YELLOW = 3'd4,
      ALL_RED_B = 3'd5
   } state_t;

   state_t        state_q, state_d, next_s;
   logic [TW-1:0] tick_cnt_q, tick_cnt_d;
   logic [3:0]    countdown_q, countdown_d;
   logic          req_ns_q, req_ns_d, req_ew_q, req_ew_d;
   logic          walk_en_q, walk_en_d;
   logic          walk_ns_q, walk_ns_d, walk_ew_q, walk_ew_d;
   logic [2:0]    light_ns_q, light_ns_d, light_ew_q, light_ew_d;
   logic          tick, timeout, go, hold;

   function automatic logic [3:0] dur_of(input state_t s);
      case (s)
         NS_GREEN, EW_GREEN:   dur_of = GREEN_CD;
         NS_YELLOW, EW_YELLOW: dur_of = YELLOW_CD;
         default:              dur_of = ALLRED_CD;
      endcase
   endfunction

   function automatic logic [5:0] lights_of(input state_t s);
      case (s)
         NS_GREEN:  lights_of = {3'b100, 3'b001};
         NS_YELLOW: lights_of = {3'b010, 3'b001};
         EW_GREEN:  lights_of = {3'b001, 3'b100};
         EW_YELLOW: lights_of = {3'b001, 3'b010};
         default:   lights_of = {3'b001, 3'b001};
      endcase
   endfunction

   always_comb begin
      state_d     = state_q;
      tick_cnt_d  = tick_cnt_q;
      countdown_d = countdown_q;
      req_ns_d    = req_ns_q | ped_btn_ns;
      req_ew_d    = req_ew_q | ped_btn_ew;
      walk_en_d   = walk_en_q;
      next_s      = state_q;
      hold        = 1'b0;
      go          = 1'b0;
      tick        = (tick_cnt_q == TICK_LAST);
      timeout     = tick && (countdown_q <= 4'd1);

      case (state_q)
         NS_GREEN: begin
            next_s = NS_YELLOW;
            hold   = emg_req && !emg_dir;
            go     = emg_req ? emg_dir : timeout;
         end
         NS_YELLOW: begin
            next_s = ALL_RED_A;
            go     = timeout;
         end
         ALL_RED_A: begin
            next_s = (emg_req && !emg_dir) ? NS_GREEN : EW_GREEN;
            go     = timeout;
         end
         EW_GREEN: begin
            next_s = EW_YELLOW;
            hold   = emg_req && emg_dir;
            go     = emg_req ? !emg_dir : timeout;
         end
         EW_YELLOW: begin
            next_s = ALL_RED_B;
            go     = timeout;
         end
         ALL_RED_B: begin
            next_s = (emg_req && emg_dir) ? EW_GREEN : NS_GREEN;
            go     = timeout;
         end
         default: begin
            next_s = ALL_RED_B;
            go     = 1'b1;
         end
      endcase

      if (go) begin
         state_d     = next_s;
         tick_cnt_d  = '0;
         countdown_d = dur_of(next_s);
         walk_en_d   = 1'b0;
         // A green entered under preemption serves no pedestrians and keeps the latch.
         if (!emg_req && next_s == NS_GREEN) begin
            walk_en_d = req_ns_d;
            req_ns_d  = 1'b0;
         end
         if (!emg_req && next_s == EW_GREEN) begin
            walk_en_d = req_ew_d;
            req_ew_d  = 1'b0;
         end
      end else if (!hold) begin
         tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
         if (tick) countdown_d = countdown_q - 4'd1;
      end

      walk_ns_d = (state_d == NS_GREEN) && walk_en_d && (countdown_d > WALK_MIN) && !emg_req;
      walk_ew_d = (state_d == EW_GREEN) && walk_en_d && (countdown_d > WALK_MIN) && !emg_req;
      {light_ns_d, light_ew_d} = lights_of(state_d);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= NS_GREEN;
         tick_cnt_q  <= '0;
         countdown_q <= GREEN_CD;
         req_ns_q    <= 1'b0;
         req_ew_q    <= 1'b0;
         walk_en_q   <= 1'b0;
         walk_ns_q   <= 1'b0;
         walk_ew_q   <= 1'b0;
         light_ns_q  <= 3'b100;
         light_ew_q  <= 3'b001;
      end else begin
         state_q     <= state_d;
         tick_cnt_q  <= tick_cnt_d;
         countdown_q <= countdown_d;
         req_ns_q    <= req_ns_d;
         req_ew_q    <= req_ew_d;
         walk_en_q   <= walk_en_d;
         walk_ns_q   <= walk_ns_d;
         walk_ew_q   <= walk_ew_d;
         light_ns_q  <= light_ns_d;
         light_ew_q  <= light_ew_d;
      end
   end

   assign phase     = state_q;
   assign countdown = countdown_q;
   assign light_ns  = light_ns_q;
   assign light_ew  = light_ew_q;
   assign walk_ns   = walk_ns_q;
   assign walk_ew   = walk_ew_q;

endmodule

// File: tb/tb_intersection_phase_scheduler.sv
// Bench for intersection_phase_scheduler: directed scenarios plus random traffic,
// all cycles scored against a seconds-level behavioural model of the intersection.
module tb_intersection_phase_scheduler;
   localparam int TD = 4, GT = 9, YT = 3, AT = 1, WT = 5;

   logic clk = 1'b0;
   logic rst = 1'b1, ped_btn_ns = 1'b0, ped_btn_ew = 1'b0, emg_req = 1'b0, emg_dir = 1'b0;
   logic [2:0] light_ns, light_ew, phase;
   logic       walk_ns, walk_ew;
   logic [3:0] countdown;

   intersection_phase_scheduler #(
      .TICK_DIV(TD), .GREEN_T(GT), .YELLOW_T(YT), .ALLRED_T(AT), .WALK_T(WT)
   ) dut (
      .clk(clk), .rst(rst), .ped_btn_ns(ped_btn_ns), .ped_btn_ew(ped_btn_ew),
      .emg_req(emg_req), .emg_dir(emg_dir), .light_ns(light_ns), .light_ew(light_ew),
      .walk_ns(walk_ns), .walk_ew(walk_ew), .countdown(countdown), .phase(phase)
   );

   always #5 clk = ~clk;

   int total = 0, bad = 0;

   // model: phase index, seconds left, cycles into the current second
   int       m_ph = 0, m_cd = GT, m_sub = 0;
   bit [1:0] m_req = 2'b00;
   bit       m_served = 1'b0;
   bit [1:0] m_walk = 2'b00;
   bit       mon_en = 1'b0;

   function automatic int dur(input int p);
      if (p == 0 || p == 3) return GT;
      if (p == 1 || p == 4) return YT;
      return AT;
   endfunction

   function automatic logic [5:0] lights_of(input int p);
      case (p)
         0: return {3'b100, 3'b001};
         1: return {3'b010, 3'b001};
         3: return {3'b001, 3'b100};
         4: return {3'b001, 3'b010};
         default: return {3'b001, 3'b001};
      endcase
   endfunction

   task automatic model_edge();
      bit go;
      int dest;
      bit green_dir;
      if (rst) begin
         m_ph = 0; m_cd = GT; m_sub = 0; m_req = 2'b00; m_served = 1'b0; m_walk = 2'b00;
      end else begin
         m_req[0] = m_req[0] | ped_btn_ns;
         m_req[1] = m_req[1] | ped_btn_ew;
         go = 1'b0;
         green_dir = (m_ph == 3);
         if ((m_ph == 0 || m_ph == 3) && emg_req) begin
            if (emg_dir != green_dir) go = 1'b1;
         end else begin
            m_sub = m_sub + 1;
            if (m_sub == TD) begin
               m_sub = 0;
               if (m_cd == 1) go = 1'b1;
               else m_cd = m_cd - 1;
            end
         end
         if (go) begin
            if (m_ph == 2 || m_ph == 5) dest = emg_req ? (emg_dir ? 3 : 0) : (m_ph == 2 ? 3 : 0);
            else dest = m_ph + 1;
            m_ph = dest; m_sub = 0; m_cd = dur(dest); m_served = 1'b0;
            if ((dest == 0 || dest == 3) && !emg_req) begin
               m_served = m_req[dest == 3];
               m_req[dest == 3] = 1'b0;
            end
         end
         m_walk[0] = (m_ph == 0) && m_served && (m_cd > GT - WT) && !emg_req;
         m_walk[1] = (m_ph == 3) && m_served && (m_cd > GT - WT) && !emg_req;
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      mon_en = 1'b1;
      #1;
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         total++;
         if (phase !== 3'(m_ph) || countdown !== 4'(m_cd) || {light_ns, light_ew} !== lights_of(m_ph)
             || walk_ns !== m_walk[0] || walk_ew !== m_walk[1]) begin
            bad++;
            $display("FAIL model t=%0t phase=%0d exp=%0d cd=%0d exp=%0d lights=%b/%b exp=%b walk=%b%b exp=%b%b",
                     $time, phase, m_ph, countdown, m_cd, light_ns, light_ew, lights_of(m_ph),
                     walk_ns, walk_ew, m_walk[0], m_walk[1]);
         end
         total++;
         if (light_ns !== 3'b001 && light_ew !== 3'b001) begin
            bad++;
            $display("FAIL safety t=%0t light_ns=%b light_ew=%b required one red", $time, light_ns, light_ew);
         end
      end
   end

   task automatic do_reset();
      ped_btn_ns = 0; ped_btn_ew = 0; emg_req = 0; emg_dir = 0;
      rst = 1; step(); step(); rst = 0;
   endtask

   task automatic wait_phase(input logic [2:0] p, input int budget, output bit ok);
      for (int i = 0; i < budget && phase !== p; i++) step();
      ok = (phase === p);
   endtask

   task automatic test_reset();
      rst = 1; emg_req = 1; emg_dir = 1; ped_btn_ns = 1; ped_btn_ew = 1;
      for (int i = 0; i < 3; i++) begin
         step();
         total++;
         if (phase !== 3'd0 || countdown !== 4'd9 || light_ns !== 3'b100 || light_ew !== 3'b001
             || walk_ns !== 1'b0 || walk_ew !== 1'b0) begin
            bad++;
            $display("FAIL reset_state phase=%0d cd=%0d lights=%b/%b walk=%b%b required 0 9 100/001 00",
                     phase, countdown, light_ns, light_ew, walk_ns, walk_ew);
         end
      end
      ped_btn_ns = 0; ped_btn_ew = 0; emg_req = 0; emg_dir = 0;
   endtask

   task automatic test_normal_cycle();
      int exp_dwell[6] = '{36, 12, 4, 36, 12, 4};
      int exp_next[6]  = '{1, 2, 3, 4, 5, 0};
      int idx = 0, run = 1, s = 0;
      logic [2:0] cur;
      do_reset();
      cur = phase;
      total++;
      if (countdown !== 4'd9) begin bad++; $display("FAIL ns_cd_start got=%0d exp=9", countdown); end
      for (int i = 0; i < 300 && idx < 6; i++) begin
         step();
         if (phase === cur) begin
            run++;
            if (idx == 0) begin
               s++;
               total++;
               if (countdown !== 4'(9 - s / 4)) begin
                  bad++; $display("FAIL ns_cd_step sample=%0d got=%0d exp=%0d", s, countdown, 9 - s / 4);
               end
            end
         end else begin
            total++;
            if (run != exp_dwell[idx] || phase !== 3'(exp_next[idx])) begin
               bad++;
               $display("FAIL dwell phase=%0d dwell=%0d exp=%0d next=%0d exp=%0d",
                        cur, run, exp_dwell[idx], phase, exp_next[idx]);
            end
            cur = phase; run = 1; idx++;
         end
      end
      total++;
      if (idx != 6) begin bad++; $display("FAIL cycle_timeout changes=%0d exp=6", idx); end
   endtask

   task automatic test_ped_ew();
      bit ok;
      int walks = 0;
      bit late_walk = 0;
      do_reset();
      for (int i = 0; i < int'($urandom_range(1, 30)); i++) step();
      ped_btn_ew = 1; step(); ped_btn_ew = 0;
      wait_phase(3'd3, 200, ok);
      total++;
      if (!ok) begin bad++; $display("FAIL ped_ew_reach got=%0d exp=3", phase); end
      for (int i = 0; i < 36; i++) begin
         total++;
         if (walk_ew !== (i < 20)) begin
            bad++; $display("FAIL ped_ew_walk cycle=%0d got=%b exp=%b", i, walk_ew, i < 20);
         end
         walks += int'(walk_ew);
         step();
      end
      total++;
      if (walks != 20) begin bad++; $display("FAIL ped_ew_count got=%0d exp=20", walks); end
      wait_phase(3'd3, 200, ok);
      for (int i = 0; i < 36; i++) begin late_walk |= walk_ew; step(); end
      total++;
      if (!ok || late_walk) begin
         bad++; $display("FAIL ped_ew_cleared reached=%b walk_seen=%b exp 1/0", ok, late_walk);
      end
   endtask

   task automatic test_emg_preempt();
      bit ok;
      bit moved = 0;
      do_reset();
      ped_btn_ew = 1; step(); ped_btn_ew = 0;
      for (int i = 0; i < 100 && countdown !== 4'd6; i++) step();
      emg_req = 1; emg_dir = 1;
      step();
      total++;
      if (phase !== 3'd1 || countdown !== 4'd3) begin
         bad++; $display("FAIL emg_to_yellow phase=%0d cd=%0d exp 1 3", phase, countdown);
      end
      wait_phase(3'd3, 100, ok);
      for (int i = 0; i < 60; i++) begin
         step();
         if (phase !== 3'd3 || countdown !== 4'd9 || walk_ew !== 1'b0) moved = 1;
      end
      total++;
      if (!ok || moved) begin bad++; $display("FAIL emg_hold reached=%b moved=%b exp 1/0", ok, moved); end
      emg_req = 0;
      step();
      total++;
      if (phase !== 3'd3 || countdown !== 4'd9 || walk_ew !== 1'b0) begin
         bad++; $display("FAIL emg_release phase=%0d cd=%0d walk=%b exp 3 9 0", phase, countdown, walk_ew);
      end
      wait_phase(3'd0, 200, ok);
      wait_phase(3'd3, 200, ok);
      total++;
      if (!ok || walk_ew !== 1'b1) begin
         bad++; $display("FAIL emg_latch_kept reached=%b walk=%b exp 1 1", ok, walk_ew);
      end
   endtask

   task automatic test_emg_yellow();
      bit ok;
      int run = 3;
      do_reset();
      wait_phase(3'd1, 100, ok);
      step(); step();
      emg_req = 1; emg_dir = 1;
      for (int i = 0; i < 40 && phase === 3'd1; i++) begin step(); if (phase === 3'd1) run++; end
      total++;
      if (!ok || run != 12 || phase !== 3'd2) begin
         bad++; $display("FAIL emg_yellow dwell=%0d next=%0d exp 12 2", run, phase);
      end
      run = 1;
      for (int i = 0; i < 40 && phase === 3'd2; i++) begin step(); if (phase === 3'd2) run++; end
      total++;
      if (run != 4 || phase !== 3'd3) begin
         bad++; $display("FAIL emg_allred dwell=%0d next=%0d exp 4 3", run, phase);
      end
      emg_req = 0; step();
   endtask

   task automatic test_emg_walk_ns();
      bit ok;
      bit moved = 0;
      do_reset();
      ped_btn_ns = 1; step(); ped_btn_ns = 0;
      wait_phase(3'd3, 200, ok);
      wait_phase(3'd0, 200, ok);
      for (int i = 0; i < 40 && countdown !== 4'd7; i++) step();
      total++;
      if (!ok || walk_ns !== 1'b1) begin bad++; $display("FAIL walk_ns_before got=%b exp=1", walk_ns); end
      emg_req = 1; emg_dir = 0;
      step();
      total++;
      if (walk_ns !== 1'b0 || phase !== 3'd0) begin
         bad++; $display("FAIL walk_ns_drop walk=%b phase=%0d exp 0 0", walk_ns, phase);
      end
      for (int i = 0; i < 20; i++) begin
         step();
         if (phase !== 3'd0 || countdown !== 4'd7 || walk_ns !== 1'b0) moved = 1;
      end
      total++;
      if (moved) begin bad++; $display("FAIL walk_ns_hold moved=%b exp=0", moved); end
      emg_req = 0; step();
      total++;
      if (walk_ns !== 1'b1 || countdown !== 4'd7) begin
         bad++; $display("FAIL walk_ns_resume walk=%b cd=%0d exp 1 7", walk_ns, countdown);
      end
      for (int i = 0; i < 40 && countdown !== 4'd3; i++) step();
      emg_req = 1;
      for (int i = 0; i < 8; i++) step();
      emg_req = 0; step();
      total++;
      if (walk_ns !== 1'b0 || countdown !== 4'd3) begin
         bad++; $display("FAIL walk_ns_late walk=%b cd=%0d exp 0 3", walk_ns, countdown);
      end
   endtask

   task automatic test_reset_mid();
      bit ok;
      bit any_walk = 0;
      do_reset();
      wait_phase(3'd4, 200, ok);
      ped_btn_ns = 1; ped_btn_ew = 1; step(); step();
      ped_btn_ns = 0; ped_btn_ew = 0;
      rst = 1; emg_req = 1; emg_dir = 1;
      step();
      rst = 0; emg_req = 0; emg_dir = 0;
      total++;
      if (!ok || phase !== 3'd0 || countdown !== 4'd9 || walk_ns !== 1'b0 || walk_ew !== 1'b0) begin
         bad++; $display("FAIL reset_mid phase=%0d cd=%0d exp 0 9", phase, countdown);
      end
      for (int i = 0; i < 110; i++) begin step(); any_walk |= walk_ns | walk_ew; end
      total++;
      if (any_walk) begin bad++; $display("FAIL reset_latches walk_seen=%b exp=0", any_walk); end
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 4000; i++) begin
         ped_btn_ns = ($urandom_range(0, 39) == 0);
         ped_btn_ew = ($urandom_range(0, 39) == 0);
         if ($urandom_range(0, 149) == 0) emg_req = ~emg_req;
         if ($urandom_range(0, 299) == 0) emg_dir = ~emg_dir;
         rst = ($urandom_range(0, 1999) == 0);
         step();
      end
      rst = 0; emg_req = 0; ped_btn_ns = 0; ped_btn_ew = 0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_normal_cycle();
      test_ped_ew();
      test_emg_preempt();
      test_emg_yellow();
      test_emg_walk_ns();
      test_reset_mid();
      test_random();
      mon_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
